// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for read-need codes, pipeline stage numbers and forward selects.
// Also used by the read-need decoder and the datapath forward muxes.
package hazard_scoreboard_pkg;

   localparam logic [1:0] NEED_NONE = 2'b00;
   localparam logic [1:0] NEED_EX   = 2'b01;
   localparam logic [1:0] NEED_MEM  = 2'b10;

   localparam int ST_EX  = 1;
   localparam int ST_MEM = 2;
   localparam int ST_WB  = 3;

   localparam int FWD_RF = 0;

   // Stages between ID and the point of use; code 11 is treated as no read.
   function automatic logic [1:0] need_offset(input logic [1:0] need);
      case (need)
         NEED_NONE: need_offset = 2'd0;
         NEED_EX:   need_offset = 2'(ST_EX);
         NEED_MEM:  need_offset = 2'(ST_MEM);
         default:   need_offset = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/hazard_port_check.sv
// Per-read-port hazard/forward decision: the youngest in-flight producer of the
// source register decides whether the port stalls or which stage it forwards from.
module hazard_port_check
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int DEPTH = 4,
   parameter int SEL_W = 2
) (
   input  logic [DEPTH-2:0]           ent_valid,
   input  logic [REG_W*(DEPTH-1)-1:0] ent_dest,
   input  logic [2*(DEPTH-1)-1:0]     ent_rdy,
   input  logic [REG_W-1:0]           src,
   input  logic [1:0]                 need,
   output logic                       hazard,
   output logic [SEL_W-1:0]           sel
);

   localparam logic [SEL_W:0] LAST_ST = (SEL_W+1)'(DEPTH-1);

   logic             hit;
   logic [SEL_W-1:0] hit_stage;
   logic [1:0]       hit_rdy;
   logic [1:0]       offset;
   logic             active;
   logic [SEL_W:0]   use_stage;

   always_comb begin
      hit       = 1'b0;
      hit_stage = '0;
      hit_rdy   = '0;
      // Scan oldest to youngest so a younger match overwrites (shadows) older ones.
      for (int s = DEPTH-1; s >= 1; s--) begin
         if (ent_valid[s-1] && (ent_dest[(s-1)*REG_W +: REG_W] != '0) &&
             (ent_dest[(s-1)*REG_W +: REG_W] == src)) begin
            hit       = 1'b1;
            hit_stage = SEL_W'(s);
            hit_rdy   = ent_rdy[(s-1)*2 +: 2];
         end
      end

      offset    = need_offset(need);
      active    = hit && (src != '0) && (offset != 2'd0);
      use_stage = {1'b0, hit_stage} + (SEL_W+1)'(offset);
      hazard    = active && (use_stage <= (SEL_W+1)'(hit_rdy));

      // Producers that will have retired by the time of use come from the register file.
      sel = SEL_W'(FWD_RF);
      if (active && !hazard && (use_stage <= LAST_ST)) begin
         sel = use_stage[SEL_W-1:0];
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes through EX..WB and decides stall vs forward
// for the instruction in ID; also counts stall cycles with saturation.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_W = 5,
   parameter int NPORT = 2,
   parameter int DEPTH = 4,
   parameter int SEL_W = 2,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [2*NPORT-1:0]       id_need,
   input  logic [REG_W*NPORT-1:0]   id_src,
   input  logic                     id_wen,
   input  logic [REG_W-1:0]         id_dest,
   input  logic [1:0]               id_rdy,
   input  logic                     flush,
   output logic                     stall,
   output logic [SEL_W*NPORT-1:0]   fwd_sel,
   output logic [CNT_W-1:0]         stall_count
);

   localparam int NENT = DEPTH-1;

   logic [NENT-1:0]        valid_q, valid_d;
   logic [REG_W*NENT-1:0]  dest_q, dest_d;
   logic [2*NENT-1:0]      rdy_q, rdy_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [NPORT-1:0]       port_hazard;
   logic [SEL_W*NPORT-1:0] port_sel;

   for (genvar k = 0; k < NPORT; k++) begin : g_port
      hazard_port_check #(
         .REG_W (REG_W),
         .DEPTH (DEPTH),
         .SEL_W (SEL_W)
      ) u_port (
         .ent_valid (valid_q),
         .ent_dest  (dest_q),
         .ent_rdy   (rdy_q),
         .src       (id_src[k*REG_W +: REG_W]),
         .need      (id_need[2*k +: 2]),
         .hazard    (port_hazard[k]),
         .sel       (port_sel[k*SEL_W +: SEL_W])
      );
   end

   always_comb begin
      stall   = id_valid && !flush && (|port_hazard);
      fwd_sel = stall ? '0 : port_sel;
   end

   // Entries shift every cycle; stalled or flushed cycles inject a bubble into EX.
   always_comb begin
      valid_d = '0;
      dest_d  = '0;
      rdy_d   = '0;
      valid_d[ST_EX-1]               = id_valid && id_wen && !stall && !flush;
      dest_d[(ST_EX-1)*REG_W +: REG_W] = id_dest;
      rdy_d[(ST_EX-1)*2 +: 2]          = id_rdy;
      for (int s = 1; s < NENT; s++) begin
         valid_d[s]                 = valid_q[s-1];
         dest_d[s*REG_W +: REG_W]   = dest_q[(s-1)*REG_W +: REG_W];
         rdy_d[2*s +: 2]            = rdy_q[2*(s-1) +: 2];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      dest_q <= dest_d;
      rdy_q  <= rdy_d;
   end

   assign stall_count = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the per-instruction register-read classifier.
- Takes the decode-stage read-need codes for each source port (00 none, 01 needed at EX, 10 needed at MEM). Tracks in-flight destination writes through the pipeline.
- Each cycle it decides stall vs forward for the instruction in ID, and emits one forward-select per read port.
- Sits between decode and the ID/EX pipeline register. Also keeps a saturating stall-cycle counter.

Parameters:
- REG_W, 5, register index width.
- NPORT, 2, number of source read ports per instruction.
- DEPTH, 4, pipeline stage count including ID. Tracked stages are 1..DEPTH-1 (EX, MEM, WB for 4).
- SEL_W, 2, forward-select width. Must satisfy 2^SEL_W >= DEPTH.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_need  in  2*NPORT  per-port need code; port k occupies bits [2k+1:2k].
- id_src  in  REG_W*NPORT  per-port source register index.
- id_wen  in  1  ID instruction writes a register.
- id_dest  in  REG_W  destination register.
- id_rdy  in  2  stage whose end produces the result (1 = EX/ALU, 2 = MEM/load).
- flush  in  1  kill the ID instruction this cycle.
- stall  out  1  hold IF/ID and insert a bubble into EX.
- fwd_sel  out  SEL_W*NPORT  per-port source at use time: 0 = register file, s = result held in stage s.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State: entry[s], s = 1..DEPTH-1, each {valid, dest, rdy}. Entry s is the instruction currently in stage s.
- Entry is producing iff valid && dest != 0.
- Shift every cycle, never frozen: entry[s] <= entry[s-1] for s >= 2.
- entry[1] <= {id_valid && id_wen && !stall && !flush, id_dest, id_rdy}. When stalled or flushed, a bubble (valid = 0) enters.
- Per port k with need code n ∈ {1, 2} and src != 0, find the youngest producing entry p (smallest s) with dest == src. Older matches are shadowed and ignored.
  - If p + n <= rdy[p], the port hazards.
  - Otherwise fwd_sel[k] = p + n when p + n <= DEPTH-1, else 0.
- Ports with need 00, src == 0, or no match give fwd_sel = 0 and no hazard.
- stall = id_valid && !flush && (any port hazards). Combinational from registered entries and ID inputs.
- fwd_sel is combinational and meaningful only when stall = 0. It is forced to 0 when stall = 1.
- Need code 11 is treated as 00.
- stall_count increments by 1 on each cycle stall = 1 and saturates at all-ones. It does not increment on flushed cycles.
- Reset: all entry.valid = 0, stall_count = 0. Hence stall = 0 and fwd_sel = 0 on the first post-reset cycle regardless of inputs.
- Reset mid-stall drops all in-flight producers; no stale hazard survives.
- Simultaneous flush and hazard: flush wins, stall = 0, a bubble enters.
- Register file is write-before-read. A producer leaving stage DEPTH-1 is visible via fwd_sel = 0.

Decomposition:
- Shared package/header holds the following, reused by the read-need decoder and the datapath forward muxes:
  - need-code constants NEED_NONE = 2'b00, NEED_EX = 2'b01, NEED_MEM = 2'b10;
  - stage constants ST_EX = 1, ST_MEM = 2, ST_WB = 3;
  - FWD_RF = 0.
- One sub-module, hazard_port_check, instantiated NPORT times: inputs are the entry vector, src, and need; outputs are hazard and sel. It holds the youngest-match priority logic.

Test Plan:
- Load-use: lw $8 (id_rdy = 2), next cycle add reading $8 at EX (need 01). stall = 1 for exactly 1 cycle, then stall = 0 with fwd_sel = 3; stall_count = 1.
- ALU-ALU: add $9 (rdy 1), then add reading $9 at EX. No stall, fwd_sel = 2. Two cycles later, a reader gets fwd_sel = 0.
- Load-store data: lw $8, then sw with rt = $8 (need 10). No stall, fwd_sel = 3.
- Shadowing: add $5 (rdy 1), lw $5 (rdy 2), then reader of $5 at EX. Youngest (lw, p = 1) governs: stall 1 cycle, then fwd_sel = 3.
- $0 and flush:
  - reader of $0 after a producer with dest = 0 → no stall;
  - load-use hazard with flush = 1 → stall = 0, bubble enters, stall_count unchanged.
- Saturation/reset: CNT_W = 4, hold a permanent hazard 20 cycles → stall_count = 15. Then assert rst one cycle → stall_count = 0, stall = 0, all fwd_sel = 0.
